stdp_weight_update: RTL and testbench
=====================================

// Module: stdp_weight_update
// PURPOSE
//  Clocked pair-based STDP learning stage: owns the synaptic weight registers that feed the
//  combinational accumulator neuron, and consumes that neuron's output spike as the
//  post-synaptic event. Tracks per-synapse pre-spike age and a post-spike age; potentiates
//  causal pairs (pre then post), depresses anti-causal pairs (post then pre), saturating.
// PARAMETERS
//  NUM_SYN   16  number of input synapses (matches `num_spikes)
//  WBITS     4   weight width (matches `WBITS); unsigned
//  WMAX      15  upper weight clamp (<= 2**WBITS-1)
//  WINIT     8   weight value loaded on reset
//  WINDOW    8   STDP pairing window in cycles (>=1); ages count 0..WINDOW, WINDOW = expired
//  TBITS     4   age counter width, must hold WINDOW
//  LTP_STEP  1   potentiation increment
//  LTD_STEP  1   depression decrement
// PORTS
//  clk          in   1                 rising-edge clock
//  rst_n        in   1                 asynchronous, active-low reset
//  spikes_in    in   NUM_SYN           pre-synaptic spikes, one cycle pulse per spike
//  post_spike   in   1                 neuron spikes_out, same cycle as spikes_in
//  learn_en     in   1                 1 = weight updates allowed
//  trace_clr    in   1                 synchronous clear of all pre/post ages
//  wr_en        in   1                 host weight write strobe
//  wr_addr      in   $clog2(NUM_SYN)   host write synapse index
//  wr_data      in   WBITS             host write value (clamped to WMAX)
//  weights      out  NUM_SYN*WBITS     registered weights, packed [NUM_SYN-1:0][WBITS-1:0]
//  ltp_mask     out  NUM_SYN           registered: synapses potentiated at last edge
//  ltd_mask     out  NUM_SYN           registered: synapses depressed at last edge
// BEHAVIOUR
//  Reset (rst_n=0, async): weights[i]=WINIT, pre_age[i]=WINDOW, post_age=WINDOW,
//   ltp_mask=0, ltd_mask=0. Leaving reset is synchronous to clk.
//  Ages: per edge, if spike this cycle age<=0; else if age<WINDOW age<=age+1; else hold.
//   pre_valid[i] = spikes_in[i] | (pre_age[i]<WINDOW)  (pre within last WINDOW cycles incl. now).
//   post_valid   = post_age<WINDOW (strictly earlier post only; current post excluded).
//  LTP[i] = learn_en & post_spike & pre_valid[i].
//  LTD[i] = learn_en & spikes_in[i] & ~post_spike & post_valid.
//  LTP and LTD mutually exclusive per synapse; simultaneous pre+post is causal -> LTP.
//  Pair consumption: if LTP[i], pre_age[i]<=WINDOW at that edge (even if spikes_in[i]=1),
//   so one pre spike potentiates at most once. Post trace is not consumed by LTD.
//  Arithmetic in WBITS+1 bits: LTP w<=min(w+LTP_STEP,WMAX); LTD w<=(w<LTD_STEP)?0:w-LTD_STEP.
//  Latency: update visible on weights one cycle after the spike cycle; ltp/ltd_mask same edge.
//  learn_en=0: weights hold (except host write), ages still tracked, masks 0.
//  trace_clr=1: all ages<=WINDOW at edge, overriding spike loads; LTP/LTD that cycle still
//   evaluated with pre-clear ages and current spikes.
//  wr_en=1: weights[wr_addr]<=min(wr_data,WMAX), overriding learning on that index only;
//   its mask bits forced 0. Out-of-range wr_addr ignored.
//  No FSM beyond age counters; every cycle is a learning cycle; no backpressure.
// TESTING
//  1 Reset: rst_n low mid-run -> weights all 8, masks 0 immediately (async), ages expired.
//  2 Causal: spikes_in[3]=1 at t, post_spike=1 at t+3 -> weights[3]=9 at t+4, ltp_mask=0x0008;
//    second post at t+5 -> no change (pre consumed).
//  3 Anti-causal: post at t, spikes_in[5]=1 at t+2 -> weights[5]=7, ltd_mask=0x0020;
//    pre at t+9 (age 8=WINDOW) -> no change.
//  4 Simultaneous: spikes_in=0x0003 with post_spike=1 same cycle -> w[0],w[1] +1, no LTD.
//  5 Saturation: wr 15 to syn 2, repeat causal pairs -> stays 15; wr 0 to syn 4, LTD -> 0.
//  6 Priority: learn_en=0 pair -> no change; wr_en to syn 3 during LTP on syn 3 -> wr_data wins,
//    other synapses still potentiated; trace_clr between pre and post -> no LTP.

Source files
------------

// File: rtl/stdp_weight_update.sv
// rtl/stdp_weight_update.sv - pair-based STDP weight store with saturating LTP/LTD and host write
module stdp_weight_update #(
    parameter int NUM_SYN  = 16,
    parameter int WBITS    = 4,
    parameter int WMAX     = 15,
    parameter int WINIT    = 8,
    parameter int WINDOW   = 8,
    parameter int TBITS    = 4,
    parameter int LTP_STEP = 1,
    parameter int LTD_STEP = 1,
    parameter int ABITS    = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SYN-1:0]              spikes_in,
    input  logic                            post_spike,
    input  logic                            learn_en,
    input  logic                            trace_clr,
    input  logic                            wr_en,
    input  logic [ABITS-1:0]                wr_addr,
    input  logic [WBITS-1:0]                wr_data,
    output logic [NUM_SYN-1:0][WBITS-1:0]   weights,
    output logic [NUM_SYN-1:0]              ltp_mask,
    output logic [NUM_SYN-1:0]              ltd_mask
);

    localparam logic [TBITS-1:0] AGE_EXP = TBITS'(WINDOW);
    localparam logic [WBITS:0]   WMAX_W  = (WBITS+1)'(WMAX);
    localparam logic [WBITS:0]   LTP_W   = (WBITS+1)'(LTP_STEP);
    localparam logic [WBITS:0]   LTD_W   = (WBITS+1)'(LTD_STEP);

    logic [NUM_SYN-1:0][WBITS-1:0] w_q;
    logic [NUM_SYN-1:0][WBITS-1:0] w_next;
    logic [NUM_SYN-1:0][TBITS-1:0] pre_age;
    logic [TBITS-1:0]              post_age;
    logic [NUM_SYN-1:0]            ltp;
    logic [NUM_SYN-1:0]            ltd;
    logic [NUM_SYN-1:0]            wr_sel;
    logic                          post_valid;
    logic [WBITS:0]                wr_ext;
    logic [WBITS-1:0]              wr_val;

    assign post_valid = post_age < AGE_EXP;
    assign wr_ext     = {1'b0, wr_data};
    assign wr_val     = (wr_ext > WMAX_W) ? WMAX_W[WBITS-1:0] : wr_data;

    for (genvar i = 0; i < NUM_SYN; i++) begin : g_syn
        logic           pre_valid;
        logic [WBITS:0] w_ext;
        logic [WBITS:0] inc_w;
        logic [WBITS:0] inc_sat;
        logic [WBITS:0] dec_w;

        assign pre_valid = spikes_in[i] | (pre_age[i] < AGE_EXP);
        // A simultaneous pre+post counts as causal, so post_spike blocks LTD.
        assign ltp[i]    = learn_en & post_spike & pre_valid;
        assign ltd[i]    = learn_en & spikes_in[i] & ~post_spike & post_valid;
        // Out-of-range addresses match no index and are dropped.
        assign wr_sel[i] = wr_en && (int'(wr_addr) == i);

        assign w_ext   = {1'b0, w_q[i]};
        assign inc_w   = w_ext + LTP_W;
        assign inc_sat = (inc_w > WMAX_W) ? WMAX_W : inc_w;
        assign dec_w   = (w_ext < LTD_W) ? '0 : w_ext - LTD_W;

        assign w_next[i] = wr_sel[i] ? wr_val :
                           ltp[i]    ? inc_sat[WBITS-1:0] :
                           ltd[i]    ? dec_w[WBITS-1:0] :
                                       w_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                w_q[i]     <= WBITS'(WINIT);
                pre_age[i] <= AGE_EXP;
            end
            post_age <= AGE_EXP;
            ltp_mask <= '0;
            ltd_mask <= '0;
        end else begin
            w_q      <= w_next;
            ltp_mask <= ltp & ~wr_sel;
            ltd_mask <= ltd & ~wr_sel;
            for (int i = 0; i < NUM_SYN; i++) begin
                // A potentiating pair consumes its pre spike so it cannot pair twice.
                if (trace_clr || ltp[i])
                    pre_age[i] <= AGE_EXP;
                else if (spikes_in[i])
                    pre_age[i] <= '0;
                else if (pre_age[i] < AGE_EXP)
                    pre_age[i] <= pre_age[i] + 1'b1;
            end
            if (trace_clr)
                post_age <= AGE_EXP;
            else if (post_spike)
                post_age <= '0;
            else if (post_age < AGE_EXP)
                post_age <= post_age + 1'b1;
        end
    end

    assign weights = w_q;

endmodule

// File: tb/tb_stdp_weight_update.sv
// tb/tb_stdp_weight_update.sv - table-driven scoreboard bench for stdp_weight_update
module tb_stdp_weight_update;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       spikes_in;
    logic              post_spike;
    logic              learn_en;
    logic              trace_clr;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [3:0]        wr_data;
    logic [15:0][3:0]  weights;
    logic [15:0]       ltp_mask;
    logic [15:0]       ltd_mask;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] spk;
        logic        post, len, clr, wen;
        logic [3:0]  waddr, wdata;
        logic [15:0] ltp, ltd;
        int          idx;
        logic [3:0]  w;
    } vec_t;

    typedef struct {
        logic [15:0] ltp, ltd;
        int          idx;
        logic [3:0]  w;
        string       tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    stdp_weight_update dut (
        .clk(clk), .rst_n(rst_n), .spikes_in(spikes_in), .post_spike(post_spike),
        .learn_en(learn_en), .trace_clr(trace_clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .weights(weights), .ltp_mask(ltp_mask), .ltd_mask(ltd_mask)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [15:0] spk, logic post, logic len, logic clr, logic wen,
                                logic [3:0] waddr, logic [3:0] wdata, logic [15:0] ltp,
                                logic [15:0] ltd, int idx, logic [3:0] w);
        vec_t v;
        v.spk = spk; v.post = post; v.len = len; v.clr = clr; v.wen = wen;
        v.waddr = waddr; v.wdata = wdata; v.ltp = ltp; v.ltd = ltd; v.idx = idx; v.w = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic zero_inputs();
        spikes_in = '0; post_spike = 1'b0; learn_en = 1'b1; trace_clr = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        spikes_in = v.spk; post_spike = v.post; learn_en = v.len; trace_clr = v.clr;
        wr_en = v.wen; wr_addr = v.waddr; wr_data = v.wdata;
        sb.push_back('{ltp: v.ltp, ltd: v.ltd, idx: v.idx, w: v.w, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, " ltp_mask"}, 64'(ltp_mask), 64'(e.ltp));
        check({e.tag, " ltd_mask"}, 64'(ltd_mask), 64'(e.ltd));
        check($sformatf("%s w[%0d]", e.tag, e.idx), 64'(weights[e.idx]), 64'(e.w));
    endtask

    initial begin
        //           spk      post len clr wen addr data  ltp      ltd     idx w
        vecs.push_back(mk(16'h0008, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 3, 8));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 3, 8));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 3, 8));
        vecs.push_back(mk(16'h0000, 1, 1, 0, 0, 0, 0,  16'h0008, 16'h0000, 3, 9));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 3, 9));
        vecs.push_back(mk(16'h0000, 1, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 3, 9));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 5, 8));
        vecs.push_back(mk(16'h0020, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0020, 5, 7));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 5, 7));
        vecs.push_back(mk(16'h0020, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 5, 7));
        vecs.push_back(mk(16'h0000, 0, 1, 1, 0, 0, 0,  16'h0000, 16'h0000, 0, 8));
        vecs.push_back(mk(16'h0003, 1, 1, 0, 0, 0, 0,  16'h0003, 16'h0000, 0, 9));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 1, 9));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 1, 2, 15, 16'h0000, 16'h0000, 2, 15));
        vecs.push_back(mk(16'h0004, 1, 1, 0, 0, 0, 0,  16'h0004, 16'h0000, 2, 15));
        vecs.push_back(mk(16'h0004, 1, 1, 0, 0, 0, 0,  16'h0004, 16'h0000, 2, 15));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 1, 4, 0,  16'h0000, 16'h0000, 4, 0));
        vecs.push_back(mk(16'h0010, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0010, 4, 0));
        vecs.push_back(mk(16'h0080, 0, 0, 0, 0, 0, 0,  16'h0000, 16'h0000, 7, 8));
        vecs.push_back(mk(16'h0000, 1, 0, 0, 0, 0, 0,  16'h0000, 16'h0000, 7, 8));
        vecs.push_back(mk(16'h0000, 0, 1, 1, 0, 0, 0,  16'h0000, 16'h0000, 7, 8));
        vecs.push_back(mk(16'h0048, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 6, 8));
        vecs.push_back(mk(16'h0000, 1, 1, 0, 1, 3, 2,  16'h0040, 16'h0000, 3, 2));
        vecs.push_back(mk(16'h0000, 0, 1, 1, 0, 0, 0,  16'h0000, 16'h0000, 6, 9));
        vecs.push_back(mk(16'h0100, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 8, 8));
        vecs.push_back(mk(16'h0000, 0, 1, 1, 0, 0, 0,  16'h0000, 16'h0000, 8, 8));
        vecs.push_back(mk(16'h0000, 1, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 8, 8));
        vecs.push_back(mk(16'h0200, 1, 1, 1, 0, 0, 0,  16'h0200, 16'h0000, 9, 9));
        vecs.push_back(mk(16'h0000, 1, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 9, 9));

        zero_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset weights", 64'(weights), 64'h8888_8888_8888_8888);
        check("reset ltp_mask", 64'(ltp_mask), 64'h0);
        check("reset ltd_mask", 64'(ltd_mask), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // Mid-run async reset must clear weights, masks and both age traces.
        apply(mk(16'h0001, 1, 1, 0, 0, 0, 0, 16'h0001, 16'h0000, 0, 10), "pre_rst_a");
        apply(mk(16'h0060, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0060, 5, 6),  "pre_rst_b");
        #2;
        rst_n = 1'b0;
        zero_inputs();
        #1;
        check("async weights", 64'(weights), 64'h8888_8888_8888_8888);
        check("async ltp_mask", 64'(ltp_mask), 64'h0);
        check("async ltd_mask", 64'(ltd_mask), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(16'h0020, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 5, 8), "post_rst_c");
        apply(mk(16'h0000, 1, 1, 0, 0, 0, 0, 16'h0020, 16'h0000, 5, 9), "post_rst_d");

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard: %0d entries left expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
